// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths, requester ids and writeback request type
package regfile_wb_arbiter_pkg;
    localparam int XLEN = 64;
    localparam int AW = 5;
    localparam logic [AW-1:0] REG_ZERO = '0;
    localparam int REQ_ALU = 0;
    localparam int REQ_LD = 1;
    typedef struct packed {
        logic valid;
        logic [AW-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_req_t;
    function automatic logic is_real(wb_req_t r);
        return r.valid && r.rd != REG_ZERO;
    endfunction
    function automatic logic is_x0(wb_req_t r);
        return r.valid && r.rd == REG_ZERO;
    endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: requester handshakes, register-file write/read ports and bypass outputs
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;
    logic alu_valid;
    logic [AW-1:0] alu_rd;
    logic [XLEN-1:0] alu_data;
    logic alu_ready;
    logic ld_valid;
    logic [AW-1:0] ld_rd;
    logic [XLEN-1:0] ld_data;
    logic ld_ready;
    logic RegWrite;
    logic [AW-1:0] RD;
    logic [XLEN-1:0] WriteData;
    logic [AW-1:0] RS1, RS2;
    logic [XLEN-1:0] ReadData1, ReadData2;
    logic [XLEN-1:0] Byp1, Byp2;
    logic [15:0] wb_count;
    modport slave (
        input alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, RS1, RS2, ReadData1, ReadData2,
        output alu_ready, ld_ready, RegWrite, RD, WriteData, Byp1, Byp2, wb_count
    );
    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, RS1, RS2, ReadData1, ReadData2,
        input alu_ready, ld_ready, RegWrite, RD, WriteData, Byp1, Byp2, wb_count
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; rr_last_i=1 means requester 0 wins a tie
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       rr_last_i,
    output logic [1:0] gnt_o
);
    assign gnt_o[0] = req_i[0] && (!req_i[1] || rr_last_i);
    assign gnt_o[1] = req_i[1] && (!req_i[0] || !rr_last_i);
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between ALU and load unit
// with round-robin arbitration, x0 filtering, a registered write stage and read bypass.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input logic clk,
    input logic reset,
    regfile_wb_arbiter_if.slave bus
);
    wb_req_t req [2];
    logic [1:0] want, x0, gnt;
    logic reg_write_q, reg_write_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [15:0] cnt_q, cnt_d;
    logic rr_last_q, rr_last_d;

    always_comb begin
        req[REQ_ALU] = '{valid: bus.alu_valid, rd: bus.alu_rd, data: bus.alu_data};
        req[REQ_LD] = '{valid: bus.ld_valid, rd: bus.ld_rd, data: bus.ld_data};
        for (int i = 0; i < 2; i++) begin
            want[i] = is_real(req[i]);
            x0[i] = is_x0(req[i]);
        end
    end

    rr_arb2 u_arb (.req_i(want), .rr_last_i(rr_last_q), .gnt_o(gnt));

    // x0 writes are acknowledged without touching the port or the arbitration state
    assign bus.alu_ready = !reset && (x0[REQ_ALU] || gnt[REQ_ALU]);
    assign bus.ld_ready = !reset && (x0[REQ_LD] || gnt[REQ_LD]);

    always_comb begin
        reg_write_d = |gnt;
        rd_d = gnt[REQ_LD] ? req[REQ_LD].rd : gnt[REQ_ALU] ? req[REQ_ALU].rd : rd_q;
        wdata_d = gnt[REQ_LD] ? req[REQ_LD].data : gnt[REQ_ALU] ? req[REQ_ALU].data : wdata_q;
        cnt_d = |gnt ? cnt_q + 16'd1 : cnt_q;
        rr_last_d = &want ? gnt[REQ_LD] : rr_last_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_q <= 1'b0;
            rd_q <= '0;
            wdata_q <= '0;
            cnt_q <= '0;
            rr_last_q <= 1'b1;
        end else begin
            reg_write_q <= reg_write_d;
            rd_q <= rd_d;
            wdata_q <= wdata_d;
            cnt_q <= cnt_d;
            rr_last_q <= rr_last_d;
        end
    end

    assign bus.RegWrite = reg_write_q;
    assign bus.RD = rd_q;
    assign bus.WriteData = wdata_q;
    assign bus.wb_count = cnt_q;
    // the in-flight write is not yet visible in the register file, so forward it
    assign bus.Byp1 = (reg_write_q && rd_q == bus.RS1 && bus.RS1 != REG_ZERO) ? wdata_q : bus.ReadData1;
    assign bus.Byp2 = (reg_write_q && rd_q == bus.RS2 && bus.RS2 != REG_ZERO) ? wdata_q : bus.ReadData2;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios plus random traffic against a
// behavioural model of arbitration, write latency, register contents and bypass.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    logic [63:0] rf [32];
    logic [63:0] m_regs [32];
    logic m_rw = 1'b0;
    logic [4:0] m_rd = '0;
    logic [63:0] m_wd = '0;
    int m_cnt = 0;
    logic m_alu_next = 1'b1;
    logic acc_a, acc_l;
    int c0;

    regfile_wb_arbiter_if bus();
    regfile_wb_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    always #100 clk = ~clk;

    always @(posedge clk) if (bus.RegWrite && bus.RD != 0) rf[bus.RD] <= bus.WriteData;
    assign bus.ReadData1 = bus.RS1 == 0 ? 64'd0 : rf[bus.RS1];
    assign bus.ReadData2 = bus.RS2 == 0 ? 64'd0 : rf[bus.RS2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_read(input logic [4:0] rs);
        if (rs != 0 && m_rw && m_rd == rs) return m_wd;
        return m_regs[rs];
    endfunction

    task automatic step();
        logic a_x0, l_x0, a_w, l_w;
        int win;
        @(negedge clk);
        a_x0 = bus.alu_valid && bus.alu_rd == 0;
        l_x0 = bus.ld_valid && bus.ld_rd == 0;
        a_w = bus.alu_valid && bus.alu_rd != 0;
        l_w = bus.ld_valid && bus.ld_rd != 0;
        win = -1;
        if (a_w && l_w) win = m_alu_next ? 0 : 1;
        else if (a_w) win = 0;
        else if (l_w) win = 1;
        acc_a = a_x0 || win == 0;
        acc_l = l_x0 || win == 1;
        chk("alu_ready", bus.alu_ready, acc_a);
        chk("ld_ready", bus.ld_ready, acc_l);
        chk("byp1", bus.Byp1, ref_read(bus.RS1));
        chk("byp2", bus.Byp2, ref_read(bus.RS2));
        @(posedge clk);
        if (m_rw && m_rd != 0) m_regs[m_rd] = m_wd;
        if (a_w && l_w) m_alu_next = (win == 1);
        m_rw = win >= 0;
        if (win == 0) begin m_rd = bus.alu_rd; m_wd = bus.alu_data; m_cnt++; end
        if (win == 1) begin m_rd = bus.ld_rd; m_wd = bus.ld_data; m_cnt++; end
        #1;
        chk("regwrite", bus.RegWrite, m_rw);
        chk("rd", bus.RD, m_rd);
        chk("wdata", bus.WriteData, m_wd);
        chk("wb_count", bus.wb_count, 64'(16'(m_cnt)));
    endtask

    task automatic draw_alu(input bit allow_x0);
        bus.alu_valid = $urandom_range(0, 2) != 0;
        bus.alu_rd = (allow_x0 && $urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.alu_data = {$urandom, $urandom};
    endtask

    task automatic draw_ld(input bit allow_x0);
        bus.ld_valid = $urandom_range(0, 2) != 0;
        bus.ld_rd = (allow_x0 && $urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.ld_data = {$urandom, $urandom};
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin rf[i] = '0; m_regs[i] = '0; end
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.ld_valid = 0; bus.ld_rd = 0; bus.ld_data = 0;
        bus.RS1 = 0; bus.RS2 = 0;
        #50;
        chk("rst_regwrite", bus.RegWrite, 0);
        chk("rst_rd", bus.RD, 0);
        chk("rst_wdata", bus.WriteData, 0);
        chk("rst_count", bus.wb_count, 0);
        @(posedge clk); #1 reset = 0;
        // single write x9=100
        bus.alu_valid = 1; bus.alu_rd = 9; bus.alu_data = 100;
        #1 chk("single_ready", bus.alu_ready, 1);
        step();
        chk("single_rw", bus.RegWrite, 1);
        chk("single_rd", bus.RD, 9);
        bus.alu_valid = 0;
        step();
        bus.RS1 = 9;
        #1 chk("single_read", bus.ReadData1, 100);
        // conflict: ALU wins first tie, load follows
        c0 = m_cnt;
        bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 55;
        bus.ld_valid = 1; bus.ld_rd = 6; bus.ld_data = 66;
        #1 chk("conf_alu_ready", bus.alu_ready, 1);
        chk("conf_ld_wait", bus.ld_ready, 0);
        step();
        bus.alu_valid = 0;
        step();
        chk("conf_ld_rd", bus.RD, 6);
        bus.ld_valid = 0;
        chk("conf_count", bus.wb_count, 64'(c0 + 2));
        // fairness with both held valid
        c0 = m_cnt;
        bus.alu_valid = 1; bus.ld_valid = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (acc_a) draw_alu(0);
            if (acc_l) draw_ld(0);
            bus.alu_valid = 1; bus.ld_valid = 1;
        end
        bus.alu_valid = 0; bus.ld_valid = 0;
        chk("fair_count", bus.wb_count, 64'(c0 + 6));
        step();
        // x0 drop alongside a real write
        c0 = m_cnt;
        bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 250;
        bus.ld_valid = 1; bus.ld_rd = 3; bus.ld_data = 42;
        #1 chk("x0_alu_ready", bus.alu_ready, 1);
        chk("x0_ld_ready", bus.ld_ready, 1);
        step();
        bus.alu_valid = 0; bus.ld_valid = 0;
        chk("x0_count", bus.wb_count, 64'(c0 + 1));
        step();
        bus.RS1 = 3; bus.RS2 = 0;
        #1 chk("x3_read", bus.ReadData1, 42);
        chk("x0_read", bus.Byp2, 0);
        // bypass during the in-flight write
        bus.alu_valid = 1; bus.alu_rd = 9; bus.alu_data = 250;
        step();
        bus.alu_valid = 0; bus.RS1 = 9;
        #1 chk("byp_raw_old", bus.ReadData1, 100);
        chk("byp_fwd", bus.Byp1, 250);
        step();
        // reset lands between grant edge and the register-file write
        bus.alu_valid = 1; bus.alu_rd = 9; bus.alu_data = 77;
        step();
        bus.alu_valid = 0;
        #49 reset = 1;
        #1 chk("rstmid_rw", bus.RegWrite, 0);
        chk("rstmid_count", bus.wb_count, 0);
        m_rw = 0; m_rd = 0; m_wd = 0; m_cnt = 0; m_alu_next = 1;
        bus.alu_valid = 1; bus.alu_rd = 0;
        #1 chk("rstmid_x0_ready", bus.alu_ready, 0);
        bus.alu_valid = 0;
        @(posedge clk); #1 reset = 0;
        #1 chk("rstmid_x9_kept", bus.ReadData1, 250);
        // random traffic
        draw_alu(1); draw_ld(1);
        for (int i = 0; i < 400; i++) begin
            step();
            if (!bus.alu_valid || acc_a) draw_alu(1);
            if (!bus.ld_valid || acc_l) draw_ld(1);
            bus.RS1 = 5'($urandom_range(0, 31));
            bus.RS2 = ($urandom_range(0, 1) == 1) ? bus.RD : 5'($urandom_range(0, 31));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
